// File: rtl/mem_io_bus_pkg.sv
// Address map, status bit positions and region decode shared by the Hack
// CPU memory/IO bus stage.
package mem_io_bus_pkg;

    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] IO_BASE     = 15'h6000;
    localparam logic [14:0] LED_ADDR    = 15'h6000;
    localparam logic [14:0] BUT_ADDR    = 15'h6001;
    localparam logic [14:0] UART_ADDR   = 15'h6002;

    localparam int BUT_FLAG_LSB   = 4;
    localparam int UART_CLEAR_BIT = 14;

    // Encoding doubles as the select for the write-enable demux.
    typedef enum logic [1:0] {
        REGION_RAM    = 2'd0,
        REGION_SCREEN = 2'd1,
        REGION_IO     = 2'd2,
        REGION_NONE   = 2'd3
    } region_e;

    function automatic region_e decodeRegion(input logic [14:0] addr);
        region_e r;
        if (addr < SCREEN_BASE) begin
            r = REGION_RAM;
        end else if (addr < IO_BASE) begin
            r = REGION_SCREEN;
        end else if (addr <= UART_ADDR) begin
            r = REGION_IO;
        end else begin
            r = REGION_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_io_bus_if.sv
// Bundle of CPU data-port, memory/screen and board I/O signals around the
// bus stage; slave is the bus stage itself, master is everything around it.
interface mem_io_bus_if;

    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [15:0] mem_din;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic [12:0] screen_addr;
    logic        screen_we;
    logic [15:0] screen_dout;
    logic [15:0] led;
    logic [3:0]  but;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    modport slave (
        input  addressM, outM, writeM, ram_dout, screen_dout, but, uart_tx_ready,
        output inM, mem_din, ram_addr, ram_we, screen_addr, screen_we, led,
               uart_tx_data, uart_tx_valid
    );

    modport master (
        output addressM, outM, writeM, ram_dout, screen_dout, but, uart_tx_ready,
        input  inM, mem_din, ram_addr, ram_we, screen_addr, screen_we, led,
               uart_tx_data, uart_tx_valid
    );

endinterface

// File: rtl/mem_io_bus_dmux4way.sv
// One-bit demux primitive and the four-way write-enable demux built from it
// (outputs ordered RAM, screen, IO, none).
module Dmux (
    input  logic in_i,
    input  logic sel_i,
    output logic a_o,
    output logic b_o
);
    assign a_o = in_i & ~sel_i;
    assign b_o = in_i &  sel_i;
endmodule

module Dmux4Way (
    input  logic       in_i,
    input  logic [1:0] sel_i,
    output logic [3:0] out_o
);
    logic loHalf;
    logic hiHalf;

    Dmux uTop  (.in_i(in_i),   .sel_i(sel_i[1]), .a_o(loHalf),   .b_o(hiHalf));
    Dmux uLow  (.in_i(loHalf), .sel_i(sel_i[0]), .a_o(out_o[0]), .b_o(out_o[1]));
    Dmux uHigh (.in_i(hiHalf), .sel_i(sel_i[0]), .a_o(out_o[2]), .b_o(out_o[3]));
endmodule

// File: rtl/mem_io_bus.sv
// Hack CPU data-port bus stage: address decode, write-enable routing, read
// mux, and the LED, debounced-button and UART transmit-holding registers.
module mem_io_bus
    import mem_io_bus_pkg::*;
#(
    parameter int DEBOUNCE_N = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_io_bus_if.slave   bus
);

    localparam int CW = $clog2(DEBOUNCE_N);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_N - 1);

    region_e     region;
    logic [3:0]  weOnehot;
    logic        ioWe;
    logic        unusedNoneWe;
    logic        ledWe;
    logic        butWe;
    logic        uartWe;

    logic [15:0] led_q;
    logic [3:0]  syncA_q;
    logic [3:0]  syncB_q;
    logic [3:0]  level_q;
    logic [3:0]  level_d;
    logic [3:0]  flags_q;
    logic [3:0]  flags_d;
    logic [3:0]  flagClr;

    logic        pending_q;
    logic        pending_d;
    logic        overrun_q;
    logic        overrun_d;
    logic [7:0]  txData_q;
    logic [7:0]  txData_d;
    logic        drain;
    logic        accept;
    logic        drop;

    logic [15:0] readData;

    assign region = decodeRegion(bus.addressM);

    Dmux4Way uWeDemux (
        .in_i  (bus.writeM),
        .sel_i (region),
        .out_o (weOnehot)
    );

    assign bus.ram_we    = weOnehot[0];
    assign bus.screen_we = weOnehot[1];
    assign ioWe          = weOnehot[2];
    assign unusedNoneWe  = weOnehot[3];

    assign ledWe  = ioWe && (bus.addressM == LED_ADDR);
    assign butWe  = ioWe && (bus.addressM == BUT_ADDR);
    assign uartWe = ioWe && (bus.addressM == UART_ADDR);

    assign bus.mem_din     = bus.outM;
    assign bus.ram_addr    = bus.addressM[13:0];
    assign bus.screen_addr = bus.addressM[12:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
        end else if (ledWe) begin
            led_q <= bus.outM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncA_q <= '0;
            syncB_q <= '0;
        end else begin
            syncA_q <= bus.but;
            syncB_q <= syncA_q;
        end
    end

    // Level flips only after DEBOUNCE_N consecutive disagreeing samples.
    for (genvar k = 0; k < 4; k++) begin : gDebounce
        logic [CW-1:0] count_q;
        logic [CW-1:0] count_d;
        logic          levelNext;

        always_comb begin
            levelNext = level_q[k];
            count_d   = '0;
            if (syncB_q[k] != level_q[k]) begin
                if (count_q == CNT_LAST) begin
                    levelNext = ~level_q[k];
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        assign level_d[k] = levelNext;
    end

    assign flagClr = butWe ? bus.outM[BUT_FLAG_LSB +: 4] : 4'b0000;
    assign flags_d = (flags_q & ~flagClr) | (level_d & ~level_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            flags_q <= '0;
        end else begin
            level_q <= level_d;
            flags_q <= flags_d;
        end
    end

    // A byte leaving on this cycle frees the slot for a same-cycle write.
    assign drain     = pending_q & bus.uart_tx_ready;
    assign accept    = uartWe & (~pending_q | drain);
    assign drop      = uartWe & pending_q & ~drain;
    assign pending_d = accept | (pending_q & ~drain);
    assign txData_d  = accept ? bus.outM[7:0] : txData_q;
    assign overrun_d = drop | (overrun_q & ~(uartWe & bus.outM[UART_CLEAR_BIT]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            txData_q  <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            txData_q  <= txData_d;
        end
    end

    always_comb begin
        readData = 16'h0000;
        case (region)
            REGION_RAM:    readData = bus.ram_dout;
            REGION_SCREEN: readData = bus.screen_dout;
            REGION_IO: begin
                if (bus.addressM == LED_ADDR) begin
                    readData = led_q;
                end else if (bus.addressM == BUT_ADDR) begin
                    readData = {8'h00, flags_q, level_q};
                end else begin
                    readData = {pending_q, overrun_q, 6'b000000, txData_q};
                end
            end
            REGION_NONE:   readData = 16'h0000;
        endcase
    end

    assign bus.inM           = readData;
    assign bus.led           = led_q;
    assign bus.uart_tx_data  = txData_q;
    assign bus.uart_tx_valid = pending_q;

endmodule
